regfile_writeback_queue: RTL and testbench

- Producer side of the register-file write port. Accepts results (destination register + 32-bit value) from execute/memory units through a valid/ready handshake.
- Buffers results in a small in-order FIFO and drains at most one per cycle onto the register file's regWrite/writeRegister/writeData inputs.
- Exports a per-register pending vector so issue logic can stall on RAW hazards against not-yet-written results.

---
 rtl/regfile_writeback_queue.sv | 81 ++++++++
 tb/tb_regfile_writeback_queue.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order result queue draining one write per cycle into the register file.
// Define WB_FORWARD_EN to add the fwdReg/fwdHit/fwdData youngest-entry lookup.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [4:0]  inReg,
    input  logic [31:0] inData,
    input  logic        wbStall,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic [31:0] pending,
`ifdef WB_FORWARD_EN
    input  logic [4:0]  fwdReg,
    output logic        fwdHit,
    output logic [31:0] fwdData,
`endif
    output logic        full,
    output logic        empty
);
    logic [4:0]       regQ  [DEPTH];
    logic [31:0]      dataQ [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             push, pop;
    assign full    = count == (PTR_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign inReady = !full;
    // Writes to $zero complete the handshake but are dropped here.
    assign push    = inValid && inReady && inReg != 5'd0;
    assign pop     = !empty && !wbStall;
    always_ff @(posedge clock) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop) head <= head + PTR_W'(1);
            count    <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            regWrite <= pop;
            if (pop) begin
                writeRegister <= regQ[head];
                writeData     <= dataQ[head];
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) begin
            regQ[tail]  <= inReg;
            dataQ[tail] <= inData;
        end
    end
    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++)
            if ((PTR_W+1)'(k) < count) pending[regQ[head + PTR_W'(k)]] = 1'b1;
        pending[0] = 1'b0;
    end
`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the last match is the youngest entry.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_W+1)'(k) < count && regQ[head + PTR_W'(k)] == fwdReg && fwdReg != 5'd0) begin
                fwdHit  = 1'b1;
                fwdData = dataQ[head + PTR_W'(k)];
            end
        end
    end
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: scoreboard bench for the write-back queue.
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        wbStall = 1'b0;
    logic [4:0]  inReg = '0;
    logic [31:0] inData = '0;
    logic        inReady, regWrite, full, empty;
    logic [4:0]  writeRegister;
    logic [31:0] writeData, pending;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwdReg = '0;
    logic        fwdHit;
    logic [31:0] fwdData;
`endif
    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [36:0] expQ[$];

    always #5 clock = ~clock;

    regfile_writeback_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clock(clock),
        .reset(reset),
        .inValid(inValid),
        .inReady(inReady),
        .inReg(inReg),
        .inData(inData),
        .wbStall(wbStall),
        .regWrite(regWrite),
        .writeRegister(writeRegister),
        .writeData(writeData),
        .pending(pending),
`ifdef WB_FORWARD_EN
        .fwdReg(fwdReg),
        .fwdHit(fwdHit),
        .fwdData(fwdData),
`endif
        .full(full),
        .empty(empty)
    );

    // One clock: record accepted results, then compare any write strobe against the oldest expected one.
    task automatic step();
        logic acc;
        logic [36:0] e;
        acc = inValid && inReady;
        @(posedge clock);
        if (reset) expQ.delete();
        else if (acc && inReg != 5'd0) expQ.push_back({inReg, inData});
        #1;
        if (acc) inValid = 1'b0;
        if (regWrite) begin
            strobes++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got reg=%0d data=%h want none", writeRegister, writeData);
            end else begin
                e = expQ.pop_front();
                if ({writeRegister, writeData} !== e) begin
                    errors++;
                    $display("FAIL sb_write got reg=%0d data=%h want reg=%0d data=%h", writeRegister, writeData, e[36:32], e[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inValid = 1'b0;
        wbStall = 1'b0;
        step();
        step();
        checks++;
        if ({regWrite, writeRegister, writeData} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%0d/%h want 0/0/0", regWrite, writeRegister, writeData);
        end
        checks++;
        if (pending !== 32'd0) begin
            errors++;
            $display("FAIL reset_pending got %h want 0", pending);
        end
        checks++;
        if ({empty, full, inReady} !== 3'b101) begin
            errors++;
            $display("FAIL reset_flags got %b want 101", {empty, full, inReady});
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        inValid = 1'b1;
        inReg = 5'd17;
        inData = 32'h4;
        step();
        checks++;
        if (pending !== 32'h0002_0000 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL single_accept got pending=%h regWrite=%b want 00020000/0", pending, regWrite);
        end
        step();
        checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd17, 32'h4}) begin
            errors++;
            $display("FAIL single_write got %b/%0d/%h want 1/17/4", regWrite, writeRegister, writeData);
        end
        step();
        checks++;
        if (regWrite !== 1'b0 || pending !== 32'd0) begin
            errors++;
            $display("FAIL single_done got regWrite=%b pending=%h want 0/0", regWrite, pending);
        end
    endtask

    task automatic test_full();
        wbStall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inValid = 1'b1;
            inReg = 5'(8 + k);
            inData = 32'h100 + k;
            step();
        end
        checks++;
        if ({full, inReady, empty} !== 3'b100 || pending !== 32'h0000_0F00) begin
            errors++;
            $display("FAIL full_flags got f/r/e=%b pending=%h want 100/00000f00", {full, inReady, empty}, pending);
        end
        inValid = 1'b1;
        inReg = 5'd12;
        inData = 32'h10C;
        step();
        step();
        checks++;
        if (pending[12] !== 1'b0 || inReady !== 1'b0 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got pend12=%b inReady=%b regWrite=%b want 0/0/0", pending[12], inReady, regWrite);
        end
        wbStall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (regWrite !== 1'b1 || writeRegister !== 5'(8 + k)) begin
                errors++;
                $display("FAIL full_drain%0d got %b/%0d want 1/%0d", k, regWrite, writeRegister, 8 + k);
            end
        end
        step();
        checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd12, 32'h10C}) begin
            errors++;
            $display("FAIL full_fifth got %b/%0d/%h want 1/12/10c", regWrite, writeRegister, writeData);
        end
        step();
        checks++;
        if (empty !== 1'b1 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL full_empty got empty=%b regWrite=%b want 1/0", empty, regWrite);
        end
    endtask

    task automatic test_zero_reg();
        inValid = 1'b1;
        inReg = 5'd0;
        inData = 32'hFFFF_FFFF;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready got %b want 1", inReady);
        end
        step();
        checks++;
        if (empty !== 1'b1 || pending !== 32'd0 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL zero_drop got empty=%b pending=%h regWrite=%b want 1/0/0", empty, pending, regWrite);
        end
        step();
        checks++;
        if (regWrite !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL zero_nowrite got regWrite=%b empty=%b want 0/1", regWrite, empty);
        end
    endtask

    task automatic test_same_reg();
        int s0;
        wbStall = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            inValid = 1'b1;
            inReg = 5'd18;
            inData = 32'(k);
            step();
        end
        checks++;
        if (pending !== 32'h0004_0000) begin
            errors++;
            $display("FAIL same_pending got %h want 00040000", pending);
        end
`ifdef WB_FORWARD_EN
        fwdReg = 5'd18;
        #1;
        checks++;
        if (fwdHit !== 1'b1 || fwdData !== 32'h2) begin
            errors++;
            $display("FAIL fwd_hit got %b/%h want 1/2", fwdHit, fwdData);
        end
        fwdReg = 5'd5;
        #1;
        checks++;
        if (fwdHit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_miss got %b want 0", fwdHit);
        end
`endif
        wbStall = 1'b0;
        s0 = strobes;
        step();
        step();
        step();
        checks++;
        if (strobes - s0 !== 2) begin
            errors++;
            $display("FAIL same_strobes got %0d want 2", strobes - s0);
        end
    endtask

    task automatic test_wrap();
        int s0;
        s0 = strobes;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            inValid = 1'b1;
            inReg = 5'(1 + k % 31);
            inData = 32'h1000 + k;
            step();
            checks++;
            if (pending !== (32'd1 << (1 + k % 31)) || full !== 1'b0) begin
                errors++;
                $display("FAIL wrap_occ%0d got pending=%h full=%b want %h/0", k, pending, full, 32'd1 << (1 + k % 31));
            end
        end
        step();
        checks++;
        if (strobes - s0 !== 3 * DEPTH || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count got %0d empty=%b want %0d/1", strobes - s0, empty, 3 * DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        wbStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inValid = 1'b1;
            inReg = 5'(20 + k);
            inData = 32'hA0 + k;
            step();
        end
        checks++;
        if (pending !== 32'h0070_0000) begin
            errors++;
            $display("FAIL rmid_pending got %h want 00700000", pending);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (empty !== 1'b1 || pending !== 32'd0 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL rmid_clear got empty=%b pending=%h regWrite=%b want 1/0/0", empty, pending, regWrite);
        end
        wbStall = 1'b0;
        s0 = strobes;
        step();
        step();
        step();
        checks++;
        if (strobes - s0 !== 0) begin
            errors++;
            $display("FAIL rmid_nowrite got %0d want 0", strobes - s0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_zero_reg();
        test_same_reg();
        test_wrap();
        test_reset_mid();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
